pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the 8-bit combinational Adder.
- Splits a WIDTH-bit add/subtract into STAGES carry-chained slices, one slice per cycle.
- Input and output use valid/ready handshakes with full backpressure.
- Produces sum, carry-out and signed overflow. Used wherever wide adds must meet timing in datapath blocks.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES, ≥ 2.
- STAGES, 4, pipeline depth (number of slices); 1 ≤ STAGES ≤ WIDTH. Slice width S = WIDTH/STAGES.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- io_in_valid  input  1  operand bundle valid.
- io_in_ready  output  1  block accepts the bundle this cycle.
- io_in_A  input  WIDTH  operand A.
- io_in_B  input  WIDTH  operand B.
- io_in_Cin  input  1  carry-in; ignored when io_in_sub=1.
- io_in_sub  input  1  0: A+B+Cin; 1: A-B (A + ~B + 1).
- io_out_valid  output  1  result valid.
- io_out_ready  input  1  consumer accepts the result.
- io_out_Sum  output  WIDTH  result, modulo 2^WIDTH.
- io_out_Cout  output  1  carry out of the MSB. In subtract mode, 1 means no borrow (A ≥ B unsigned).
- io_out_Ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset is synchronous and active-high: while reset=1 at a rising edge, all stage valid bits clear.
  - io_out_valid=0, io_out_Sum=0, io_out_Cout=0, io_out_Ovf=0.
  - In-flight data is discarded. io_in_ready=0 during the reset cycle and 1 on the first cycle after.
- Pipeline has STAGES registered stages, each holding valid, carry, the completed low result slices, and the not-yet-processed upper slices of A and B'.
  - B' = sub ? ~B : B.
  - c0 = sub ? 1 : Cin.
- Stage k (k = 0..STAGES-1) computes slice k:
  - {c(k+1), R[k*S +: S]} = A[k*S +: S] + B'[k*S +: S] + c(k).
  - Stage 0 computes directly from the input ports.
  - The last stage registers Sum, Cout = c(STAGES), and Ovf.
- Ovf = (A[W-1] == B'[W-1]) && (Sum[W-1] != A[W-1]), evaluated in the last stage. A[W-1] and B'[W-1] are carried down the pipeline for this.
- Global advance: adv = !io_out_valid || io_out_ready.
  - io_in_ready = adv; this is a combinational path from io_out_ready.
  - When adv=1, every stage loads from its predecessor.
  - Stage 0 loads valid = io_in_valid, plus the input data.
  - When adv=0, all stages hold.
- Latency: a bundle accepted at edge t appears with io_out_valid=1 after edge t+STAGES-1, i.e. STAGES register stages. STAGES=1 gives a single registered adder.
- Throughput: one result per cycle while io_out_ready=1.
- Bubbles travel as valid=0 slots. They are not collapsed; a bubble in the pipe does not let input bypass the stall.
- Output stability: while io_out_valid=1 and io_out_ready=0, all io_out_* hold their values unchanged.
- Simultaneous accept and emit in one cycle is legal and costs no throughput.
- Invalid stages may hold any data. Stage data registers need no reset; only valid bits and output registers are reset.
- Wrap-around: the sum is always modulo 2^WIDTH. Carry and overflow are reported, never saturated.
- io_in_* are sampled only when io_in_valid && io_in_ready. Input values in other cycles have no effect.

Test Plan:
1. Reset mid-stream: W=32, S=4, 3 bundles in flight, then reset=1 for 1 cycle → io_out_valid=0 next cycle, no stale result ever emitted, io_in_ready=1 the cycle after reset.
2. Cross-slice carry: A=0x00FF_FFFF, B=0x0000_0001, Cin=0, sub=0 → after 4 cycles Sum=0x0100_0000, Cout=0, Ovf=0.
3. Overflow and carry: A=0x7FFF_FFFF, B=1, Cin=0 → Sum=0x8000_0000, Ovf=1, Cout=0. Then A=0xFFFF_FFFF, B=1, Cin=1 → Sum=0x0000_0001, Cout=1, Ovf=0.
4. Subtract: A=5, B=7, sub=1, Cin=1 (ignored) → Sum=0xFFFF_FFFE, Cout=0, Ovf=0. Then A=0x8000_0000, B=1, sub=1 → Sum=0x7FFF_FFFF, Cout=1, Ovf=1.
5. Backpressure: stream 10 random bundles with io_in_valid=1 while io_out_ready toggles 1,0,0,1,…
   - Outputs match a reference model in order, with none lost or duplicated.
   - Outputs stay stable while stalled.
   - io_in_ready equals adv in every cycle.
6. Parametrisation: repeat scenarios 2–5 with (WIDTH=8, STAGES=1) and (WIDTH=64, STAGES=8). Latency is STAGES cycles and full throughput is 1 per cycle when io_out_ready=1.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract built from STAGES carry-chained slices, one slice per
// stage, with valid/ready handshakes on both sides and a single global stall.
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [WIDTH-1:0] io_in_A,
   input  logic [WIDTH-1:0] io_in_B,
   input  logic             io_in_Cin,
   input  logic             io_in_sub,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [WIDTH-1:0] io_out_Sum,
   output logic             io_out_Cout,
   output logic             io_out_Ovf
);

   localparam int S = WIDTH / STAGES;

   // Operands shift down one slice per stage so every stage adds bits [S-1:0];
   // finished result slices shift in from the top and land in place after the last stage.
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] r_q [STAGES];
   logic             c_q [STAGES];
   logic             v_q [STAGES];
   logic             ovf_q;
   logic             adv;

   // One advance signal for the whole pipe: bubbles are not squeezed out.
   assign adv         = !v_q[STAGES-1] || io_out_ready;
   assign io_in_ready = adv && !reset;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] a_in, b_in, r_in, r_nxt;
      logic             c_in, v_in;
      logic [S:0]       sum;

      if (k == 0) begin : g_first
         assign a_in = io_in_A;
         assign b_in = io_in_sub ? ~io_in_B : io_in_B;
         assign c_in = io_in_sub | io_in_Cin;
         assign v_in = io_in_valid;
         assign r_in = '0;
      end else begin : g_next
         assign a_in = a_q[k-1];
         assign b_in = b_q[k-1];
         assign c_in = c_q[k-1];
         assign v_in = v_q[k-1];
         assign r_in = r_q[k-1];
      end

      assign sum   = {1'b0, a_in[S-1:0]} + {1'b0, b_in[S-1:0]} + (S+1)'(c_in);
      assign r_nxt = (r_in >> S) | (WIDTH'(sum[S-1:0]) << (WIDTH - S));

      always_ff @(posedge clock) begin
         if (reset) begin
            // NOTE: only valid bits and the visible output registers are reset; slice data
            // in inner stages is qualified by its valid bit and is left unreset.
            v_q[k] <= 1'b0;
            if (k == STAGES - 1) begin
               r_q[k] <= '0;
               c_q[k] <= 1'b0;
            end
         end else if (adv) begin
            v_q[k] <= v_in;
            a_q[k] <= a_in >> S;
            b_q[k] <= b_in >> S;
            c_q[k] <= sum[S];
            r_q[k] <= r_nxt;
         end
      end

      if (k == STAGES - 1) begin : g_last
         // Here a_in/b_in hold the top slice, so bit S-1 is the operand sign.
         always_ff @(posedge clock) begin
            if (reset) begin
               ovf_q <= 1'b0;
            end else if (adv) begin
               ovf_q <= (a_in[S-1] == b_in[S-1]) && (sum[S-1] != a_in[S-1]);
            end
         end
      end
   end

   assign io_out_valid = v_q[STAGES-1];
   assign io_out_Sum   = r_q[STAGES-1];
   assign io_out_Cout  = c_q[STAGES-1];
   assign io_out_Ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: three configurations run side by side, each with
// its own driver, ready generator and monitor checking against an arithmetic model.
module tb_pipelined_adder;

   bit clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   bit done [3];

   task automatic check(input int w, input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL [W=%0d] %s: got %0h expected %0h", w, name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int W = (g == 0) ? 32 : (g == 1) ? 8 : 64;
      localparam int N = (g == 0) ? 4  : (g == 1) ? 1 : 8;

      typedef struct {
         logic [W-1:0] sum;
         logic         cout;
         logic         ovf;
         bit           lat;
         int           t;
      } item_t;

      logic         rst, in_valid, in_ready, in_cin, in_sub;
      logic         out_valid, out_ready, out_cout, out_ovf;
      logic [W-1:0] in_a, in_b, out_sum;
      item_t        q[$];
      int           mode;

      pipelined_adder #(.WIDTH(W), .STAGES(N)) dut (
         .clock       (clk),
         .reset       (rst),
         .io_in_valid (in_valid),
         .io_in_ready (in_ready),
         .io_in_A     (in_a),
         .io_in_B     (in_b),
         .io_in_Cin   (in_cin),
         .io_in_sub   (in_sub),
         .io_out_valid(out_valid),
         .io_out_ready(out_ready),
         .io_out_Sum  (out_sum),
         .io_out_Cout (out_cout),
         .io_out_Ovf  (out_ovf)
      );

      // Reference: exact signed/unsigned arithmetic on widened values.
      function automatic item_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c, input logic s);
         item_t r;
         logic [W:0] u;
         logic signed [W+1:0] sa, sb, sr, hi, lo;
         sa = $signed({{2{a[W-1]}}, a});
         sb = $signed({{2{b[W-1]}}, b});
         hi = $signed({3'b000, {(W-1){1'b1}}});
         lo = $signed({3'b111, {(W-1){1'b0}}});
         if (s) begin
            r.sum  = a - b;
            r.cout = (a >= b);
            sr     = sa - sb;
         end else begin
            u      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            r.sum  = u[W-1:0];
            r.cout = u[W];
            sr     = sa + sb + $signed({{(W+1){1'b0}}, c});
         end
         r.ovf = (sr > hi) || (sr < lo);
         r.lat = 1'b0;
         r.t   = 0;
         return r;
      endfunction

      function automatic item_t mk(input logic [W-1:0] s, input logic c, input logic o);
         item_t r;
         r.sum = s; r.cout = c; r.ovf = o; r.lat = 1'b0; r.t = 0;
         return r;
      endfunction

      task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic s, input item_t e);
         bit acc;
         int tt;
         acc = 1'b0;
         tt  = 0;
         in_valid = 1'b1; in_a = a; in_b = b; in_cin = c; in_sub = s;
         for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            tt  = cyc + 1;
            @(posedge clk);
            if (acc) begin
               e.lat = (mode == 0);
               e.t   = tt;
               q.push_back(e);
            end
            #1;
         end
         check(W, "accept", acc, 1'b1);
         in_valid = 1'b0;
      endtask

      task automatic send_rand();
         logic [W-1:0] a, b;
         logic c, s;
         a = W'({$urandom(), $urandom()});
         b = W'({$urandom(), $urandom()});
         c = 1'($urandom());
         s = 1'($urandom());
         send(a, b, c, s, model(a, b, c, s));
      endtask

      task automatic idle(input int n);
         in_valid = 1'b0;
         in_a = W'({$urandom(), $urandom()});
         in_b = W'({$urandom(), $urandom()});
         repeat (n) @(posedge clk);
         #1;
      endtask

      task automatic drain();
         bit empty;
         empty = 1'b0;
         for (int i = 0; i < 400 && !empty; i++) begin
            @(negedge clk);
            empty = (q.size() == 0) && !out_valid;
         end
         check(W, "drained", empty, 1'b1);
         @(posedge clk);
         #1;
      endtask

      // Consumer: always ready, the 1,0,0,1 pattern, or random.
      initial begin : rdy
         int ph;
         ph = 0;
         out_ready = 1'b1;
         forever begin
            @(posedge clk);
            #1;
            case (mode)
               0:       out_ready = 1'b1;
               1:       out_ready = (ph % 4 == 0) || (ph % 4 == 3);
               default: out_ready = 1'($urandom());
            endcase
            ph++;
         end
      end

      initial begin : mon
         bit stall;
         logic [W-1:0] hs;
         logic hc, ho;
         item_t it;
         stall = 1'b0;
         hs = '0; hc = 1'b0; ho = 1'b0;
         forever begin
            @(negedge clk);
            if (rst) begin
               check(W, "in_ready_in_reset", in_ready, 1'b0);
               stall = 1'b0;
            end else begin
               check(W, "in_ready_eq_adv", in_ready, !out_valid || out_ready);
               if (stall) begin
                  check(W, "stall_valid", out_valid, 1'b1);
                  check(W, "stall_sum", out_sum, hs);
                  check(W, "stall_cout", out_cout, hc);
                  check(W, "stall_ovf", out_ovf, ho);
               end
               if (out_valid && out_ready) begin
                  check(W, "out_expected", q.size() > 0, 1'b1);
                  if (q.size() > 0) begin
                     it = q.pop_front();
                     check(W, "sum", out_sum, it.sum);
                     check(W, "cout", out_cout, it.cout);
                     check(W, "ovf", out_ovf, it.ovf);
                     if (it.lat) check(W, "latency", cyc - it.t, N - 1);
                  end
               end
               stall = out_valid && !out_ready;
               hs = out_sum; hc = out_cout; ho = out_ovf;
            end
         end
      end

      initial begin : drv
         logic [W-1:0] mx, mn;
         rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
         mode = 0;
         mx = {1'b0, {(W-1){1'b1}}};
         mn = ~mx;

         @(negedge clk);
         check(W, "rst_valid", out_valid, 1'b0);
         check(W, "rst_sum", out_sum, '0);
         check(W, "rst_cout", out_cout, 1'b0);
         check(W, "rst_ovf", out_ovf, 1'b0);
         @(posedge clk); #1 rst = 1'b0;
         @(negedge clk);
         check(W, "ready_after_reset", in_ready, 1'b1);
         @(posedge clk); #1;

         // Reset with bundles in flight: none of them may ever come out.
         repeat (3) send_rand();
         rst = 1'b1;
         q.delete();
         @(posedge clk); #1 rst = 1'b0;
         @(negedge clk);
         check(W, "midrst_valid", out_valid, 1'b0);
         check(W, "midrst_sum", out_sum, '0);
         check(W, "midrst_ready", in_ready, 1'b1);
         @(posedge clk); #1;
         idle(4);

         // Directed corners, back to back at full rate.
         send((W'(1) << (W - 8)) - W'(1), W'(1), 1'b0, 1'b0, mk(W'(1) << (W - 8), 1'b0, 1'b0));
         send(mx, W'(1), 1'b0, 1'b0, mk(mn, 1'b0, 1'b1));
         send('1, W'(1), 1'b1, 1'b0, mk(W'(1), 1'b1, 1'b0));
         send(W'(5), W'(7), 1'b1, 1'b1, mk(~W'(1), 1'b0, 1'b0));
         send(mn, W'(1), 1'b0, 1'b1, mk(mx, 1'b1, 1'b1));
         drain();

         mode = 1;
         repeat (10) send_rand();
         drain();

         mode = 2;
         repeat (30) begin
            send_rand();
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         end
         drain();

         mode = 0;
         repeat (12) send_rand();
         drain();
         done[g] = 1'b1;
      end
   end

   initial begin
      for (int i = 0; i < 50000 && !(done[0] && done[1] && done[2]); i++) @(posedge clk);
      check(0, "all_done", done[0] && done[1] && done[2], 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
